cflog_write_ctrl: RTL and testbench

- Sequences control-flow log (CFLog) writes from the cflow monitor into the protected META log region.
- Serialises each (src, dest) event into two word writes and maintains the log pointer.
- Raises a flush request to the TCB when the log fills or when ER execution completes, and stalls the CPU until the TCB acknowledges.
- Sits between the cflow monitor and the log RAM write port.

---
 rtl/cflog_write_ctrl.sv | 94 +++++++++
 tb/tb_cflog_write_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cflog_write_ctrl.sv
// cflog_write_ctrl: serialises control-flow events into the META log and drives the TCB flush handshake
module cflog_write_ctrl #(
    parameter logic [15:0] LOG_BASE  = 16'h0140,
    parameter int          LOG_WORDS = 128
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic        cf_valid,
    input  logic [15:0] cf_src,
    input  logic [15:0] cf_dest,
    input  logic        er_done,
    input  logic        flush_ack,
    output logic        cf_ready,
    output logic        log_wen,
    output logic [15:0] log_addr,
    output logic [15:0] log_data,
    output logic [15:0] cflow_log_ptr,
    output logic        flush_req,
    output logic        flush_final,
    output logic        cpu_stall,
    output logic        lost_err
);
    typedef enum logic [1:0] {IDLE, WR_SRC, WR_DST, FLUSH} state_t;

    localparam logic [8:0] FULL = 9'(LOG_WORDS);

    state_t      state, state_nxt;
    logic [8:0]  ptr;
    logic [15:0] src_q, dst_q, addr_q, data_q, wr_addr, wr_data;
    logic        pending, final_q, lost_q, wr, er_any, full_nxt;

    // next-state decode and write-port datapath
    always_comb begin
        state_nxt = state;
        wr        = (state == WR_SRC) || (state == WR_DST);
        er_any    = er_done | pending;
        full_nxt  = (ptr + 9'd1) == FULL;
        wr_addr   = LOG_BASE + {6'd0, ptr, 1'b0};
        wr_data   = (state == WR_SRC) ? src_q : dst_q;
        case (state)
            IDLE:    state_nxt = cf_valid ? WR_SRC : (er_any ? FLUSH : IDLE);
            WR_SRC:  state_nxt = WR_DST;
            WR_DST:  state_nxt = (full_nxt || er_any) ? FLUSH : IDLE;
            FLUSH:   state_nxt = flush_ack ? IDLE : FLUSH;
            default: state_nxt = IDLE;
        endcase
    end

    // state, pointer, captured event, pending er_done and sticky error registers
    always_ff @(posedge clk) begin
        if (!puc_n) begin
            state   <= IDLE;
            ptr     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= LOG_BASE;
            data_q  <= '0;
            pending <= 1'b0;
            final_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr) begin
                ptr    <= ptr + 9'd1;
                addr_q <= wr_addr;
                data_q <= wr_data;
            end else if (state == FLUSH && flush_ack) begin
                ptr <= '0;
            end
            if (state == IDLE && cf_valid) begin
                src_q <= cf_src;
                dst_q <= cf_dest;
            end
            if (state_nxt == FLUSH && state != FLUSH) begin
                final_q <= er_any;
                pending <= 1'b0;
            end else if (er_done) begin
                pending <= 1'b1;
            end
            if (cf_valid && state != IDLE)
                lost_q <= 1'b1;
        end
    end

    assign cf_ready      = state == IDLE;
    assign cpu_stall     = state == FLUSH;
    assign flush_req     = state == FLUSH;
    assign flush_final   = (state == FLUSH) & final_q;
    assign log_wen       = wr;
    assign log_addr      = wr ? wr_addr : addr_q;
    assign log_data      = wr ? wr_data : data_q;
    assign cflow_log_ptr = {7'd0, ptr};
    assign lost_err      = lost_q;
endmodule

// File: tb/tb_cflog_write_ctrl.sv
// tb_cflog_write_ctrl: directed self-checking bench for the CFLog write controller
module tb_cflog_write_ctrl;
    logic        clk = 1'b0;
    logic        puc_n, cf_valid, er_done, flush_ack;
    logic [15:0] cf_src, cf_dest;
    logic        cf_ready, log_wen, flush_req, flush_final, cpu_stall, lost_err;
    logic [15:0] log_addr, log_data, cflow_log_ptr;
    int          tests = 0;
    int          fails = 0;

    cflog_write_ctrl dut (
        .clk(clk), .puc_n(puc_n), .cf_valid(cf_valid), .cf_src(cf_src), .cf_dest(cf_dest),
        .er_done(er_done), .flush_ack(flush_ack), .cf_ready(cf_ready), .log_wen(log_wen),
        .log_addr(log_addr), .log_data(log_data), .cflow_log_ptr(cflow_log_ptr),
        .flush_req(flush_req), .flush_final(flush_final), .cpu_stall(cpu_stall), .lost_err(lost_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " cf_ready"}, 16'(cf_ready), 16'd1);
        chk({tag, " log_wen"}, 16'(log_wen), 16'd0);
        chk({tag, " log_addr"}, log_addr, 16'h0140);
        chk({tag, " log_data"}, log_data, 16'h0000);
        chk({tag, " ptr"}, cflow_log_ptr, 16'd0);
        chk({tag, " flush_req"}, 16'(flush_req), 16'd0);
        chk({tag, " flush_final"}, 16'(flush_final), 16'd0);
        chk({tag, " cpu_stall"}, 16'(cpu_stall), 16'd0);
        chk({tag, " lost_err"}, 16'(lost_err), 16'd0);
    endtask

    initial begin
        puc_n = 1'b0; cf_valid = 1'b0; er_done = 1'b0; flush_ack = 1'b0;
        cf_src = '0; cf_dest = '0;
        tick(); tick();
        puc_n = 1'b1;
        chk_reset("reset");

        // single event; inputs scrambled after acceptance to prove capture
        cf_valid = 1'b1; cf_src = 16'hE000; cf_dest = 16'hE01A;
        tick();
        cf_valid = 1'b0; cf_src = 16'h5555; cf_dest = 16'h6666;
        chk("ev1 src wen", 16'(log_wen), 16'd1);
        chk("ev1 src addr", log_addr, 16'h0140);
        chk("ev1 src data", log_data, 16'hE000);
        chk("ev1 busy", 16'(cf_ready), 16'd0);
        tick();
        chk("ev1 dst wen", 16'(log_wen), 16'd1);
        chk("ev1 dst addr", log_addr, 16'h0142);
        chk("ev1 dst data", log_data, 16'hE01A);
        chk("ev1 mid ptr", cflow_log_ptr, 16'd1);
        tick();
        chk("ev1 ready", 16'(cf_ready), 16'd1);
        chk("ev1 ptr", cflow_log_ptr, 16'd2);
        chk("ev1 idle wen", 16'(log_wen), 16'd0);
        chk("ev1 hold addr", log_addr, 16'h0142);
        chk("ev1 hold data", log_data, 16'hE01A);
        chk("ev1 no flush", 16'(flush_req), 16'd0);

        // fill the log from empty: 64 events, 128 words
        puc_n = 1'b0;
        tick();
        puc_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cf_valid = 1'b1; cf_src = 16'h1000 + 16'(i); cf_dest = 16'h2000 + 16'(i);
            tick();
            cf_valid = 1'b0;
            chk("fill src addr", log_addr, 16'h0140 + 16'(4 * i));
            chk("fill src data", log_data, 16'h1000 + 16'(i));
            tick();
            chk("fill dst addr", log_addr, 16'h0142 + 16'(4 * i));
            chk("fill dst data", log_data, 16'h2000 + 16'(i));
            tick();
            if (i < 63) chk("fill no flush", 16'(flush_req), 16'd0);
        end
        chk("full last addr", log_addr, 16'h023E);
        chk("full flush_req", 16'(flush_req), 16'd1);
        chk("full final", 16'(flush_final), 16'd0);
        chk("full stall", 16'(cpu_stall), 16'd1);
        chk("full ptr", cflow_log_ptr, 16'd128);
        chk("full ready", 16'(cf_ready), 16'd0);
        chk("full lost", 16'(lost_err), 16'd0);
        tick(); tick();
        chk("full wait req", 16'(flush_req), 16'd1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("full ack req", 16'(flush_req), 16'd0);
        chk("full ack ptr", cflow_log_ptr, 16'd0);
        chk("full ack ready", 16'(cf_ready), 16'd1);
        cf_valid = 1'b1; cf_src = 16'hAAAA; cf_dest = 16'hBBBB;
        tick();
        cf_valid = 1'b0;
        chk("wrap addr", log_addr, 16'h0140);
        chk("wrap data", log_data, 16'hAAAA);
        tick(); tick();
        chk("wrap ptr", cflow_log_ptr, 16'd2);

        // er_done during WR_SRC: both words logged, then final flush
        cf_valid = 1'b1; cf_src = 16'h1234; cf_dest = 16'h5678;
        tick();
        cf_valid = 1'b0; er_done = 1'b1;
        tick();
        er_done = 1'b0;
        chk("erd dst data", log_data, 16'h5678);
        chk("erd dst addr", log_addr, 16'h0146);
        chk("erd no flush yet", 16'(flush_req), 16'd0);
        tick();
        chk("erd flush_req", 16'(flush_req), 16'd1);
        chk("erd final", 16'(flush_final), 16'd1);
        chk("erd ptr", cflow_log_ptr, 16'd4);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("erd ack req", 16'(flush_req), 16'd0);
        chk("erd ack ptr", cflow_log_ptr, 16'd0);
        tick();
        chk("erd no reflush", 16'(flush_req), 16'd0);

        // lost events during WR_SRC and FLUSH
        cf_valid = 1'b1; cf_src = 16'h1111; cf_dest = 16'h2222;
        tick();
        cf_src = 16'h9999; cf_dest = 16'h9999;
        chk("lost pre", 16'(lost_err), 16'd0);
        tick();
        cf_valid = 1'b0;
        chk("lost set", 16'(lost_err), 16'd1);
        chk("lost dst data", log_data, 16'h2222);
        chk("lost dst addr", log_addr, 16'h0142);
        tick();
        chk("lost ptr", cflow_log_ptr, 16'd2);
        er_done = 1'b1;
        tick();
        er_done = 1'b0;
        chk("lost flush", 16'(flush_req), 16'd1);
        chk("lost final", 16'(flush_final), 16'd1);
        cf_valid = 1'b1; cf_src = 16'h7777;
        tick();
        cf_valid = 1'b0;
        chk("lost flush ptr", cflow_log_ptr, 16'd2);
        chk("lost flush wen", 16'(log_wen), 16'd0);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("lost ptr clr", cflow_log_ptr, 16'd0);
        chk("lost sticky", 16'(lost_err), 16'd1);
        chk("lost ready", 16'(cf_ready), 16'd1);

        // empty-log flush with a long-held acknowledge
        er_done = 1'b1;
        tick();
        er_done = 1'b0;
        chk("empty req", 16'(flush_req), 16'd1);
        chk("empty final", 16'(flush_final), 16'd1);
        chk("empty ptr", cflow_log_ptr, 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty hold req", 16'(flush_req), 16'd1);
            chk("empty hold stall", 16'(cpu_stall), 16'd1);
        end
        // er_done during FLUSH yields a second final flush
        er_done = 1'b1;
        tick();
        er_done = 1'b0;
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        chk("second idle", 16'(flush_req), 16'd0);
        chk("second ready", 16'(cf_ready), 16'd1);
        tick();
        chk("second req", 16'(flush_req), 16'd1);
        chk("second final", 16'(flush_final), 16'd1);
        flush_ack = 1'b1;
        tick();
        flush_ack = 1'b0;
        tick();
        chk("second done", 16'(flush_req), 16'd0);

        // reset in WR_DST with er_done pending discards everything
        cf_valid = 1'b1; cf_src = 16'hCAFE; cf_dest = 16'hBEEF;
        tick();
        cf_valid = 1'b0; er_done = 1'b1;
        tick();
        er_done = 1'b0; puc_n = 1'b0;
        chk("rst in dst data", log_data, 16'hBEEF);
        tick();
        puc_n = 1'b1;
        chk_reset("rst mid");
        tick(); tick(); tick();
        chk("rst no flush", 16'(flush_req), 16'd0);
        chk("rst no stall", 16'(cpu_stall), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
